stack_mem_ctrl: RTL and testbench

//  Sequencer in front of the single-port data memory. Accepts one load/store/PUSH/POP command at a time from the

---
 rtl/stack_mem_if.sv | 35 +++
 rtl/stack_mem_ctrl.sv | 110 +++++++++++
 tb/tb_stack_mem_ctrl.sv | 271 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/stack_mem_if.sv
// Command, response and memory-port bundle for stack_mem_ctrl.
// slave = controller side, master = execute stage plus memory.
interface stack_mem_if #(
   parameter int AW = 32,
   parameter int DW = 32
);
   logic          req_valid;
   logic          req_ready;
   logic [1:0]    req_op;
   logic [AW-1:0] req_addr;
   logic [DW-1:0] req_wdata;
   logic [4:0]    req_rd;
   logic          resp_valid;
   logic [DW-1:0] resp_rdata;
   logic [4:0]    resp_rd;
   logic          resp_err;
   logic          mem_read;
   logic          mem_write;
   logic [AW-1:0] mem_addr;
   logic [DW-1:0] mem_wdata;
   logic [DW-1:0] mem_rdata;
   logic [AW-1:0] sp;

   modport slave (
      input  req_valid, req_op, req_addr, req_wdata, req_rd, mem_rdata,
      output req_ready, resp_valid, resp_rdata, resp_rd, resp_err,
             mem_read, mem_write, mem_addr, mem_wdata, sp
   );

   modport master (
      output req_valid, req_op, req_addr, req_wdata, req_rd, mem_rdata,
      input  req_ready, resp_valid, resp_rdata, resp_rd, resp_err,
             mem_read, mem_write, mem_addr, mem_wdata, sp
   );
endinterface

// File: rtl/stack_mem_ctrl.sv
// One-command-at-a-time LOAD/STORE/PUSH/POP sequencer owning the stack pointer.
// Define STACK_BOUNDS_CHECK_EN to reject stack overflow/underflow with resp_err.
module stack_mem_ctrl #(
   parameter int            AW          = 32,
   parameter int            DW          = 32,
   parameter logic [AW-1:0] SP_INIT     = 32'h0000_1000,
   parameter logic [AW-1:0] STACK_LIMIT = 32'h0000_0C00,
   parameter int            READ_LAT    = 1
) (
   input logic        clk,
   input logic        reset,
   stack_mem_if.slave bus
);
   typedef enum logic [1:0] {IDLE, ACCESS, WAIT, RESP} state_t;

   localparam logic [1:0] OP_LOAD  = 2'b00;
   localparam logic [1:0] OP_STORE = 2'b01;
   localparam logic [1:0] OP_PUSH  = 2'b10;
   localparam logic [1:0] OP_POP   = 2'b11;
   localparam int         CW       = (READ_LAT > 1) ? $clog2(READ_LAT) : 1;

`ifdef STACK_BOUNDS_CHECK_EN
   localparam bit BOUNDS_EN = 1'b1;
`else
   localparam bit BOUNDS_EN = 1'b0;
`endif

   state_t        state;
   logic [1:0]    op;
   logic [CW-1:0] cnt;
   logic [AW-1:0] sp_q;
   logic [AW-1:0] sp_dec;
   logic [AW-1:0] sp_inc;
   logic [AW-1:0] acc_addr;
   logic          is_read;
   logic          bound_err;

   assign sp_dec   = sp_q - AW'(4);
   assign sp_inc   = sp_q + AW'(4);
   assign is_read  = (bus.req_op == OP_LOAD) || (bus.req_op == OP_POP);
   assign acc_addr = (bus.req_op == OP_PUSH) ? sp_dec :
                     (bus.req_op == OP_POP)  ? sp_q   : (bus.req_addr & ~AW'(3));
   assign bound_err = BOUNDS_EN &&
                      (((bus.req_op == OP_PUSH) && (sp_dec < STACK_LIMIT)) ||
                       ((bus.req_op == OP_POP)  && (sp_q >= SP_INIT)));
   assign bus.sp = sp_q;

   always_ff @(posedge clk) begin
      if (reset) begin
         state          <= IDLE;
         op             <= OP_LOAD;
         cnt            <= '0;
         sp_q           <= SP_INIT;
         bus.req_ready  <= 1'b1;
         bus.resp_valid <= 1'b0;
         bus.resp_rdata <= '0;
         bus.resp_rd    <= '0;
         bus.resp_err   <= 1'b0;
         bus.mem_read   <= 1'b0;
         bus.mem_write  <= 1'b0;
         bus.mem_addr   <= '0;
         bus.mem_wdata  <= '0;
      end else begin
         unique case (state)
            IDLE: if (bus.req_valid) begin
               op            <= bus.req_op;
               bus.resp_rd   <= bus.req_rd;
               bus.req_ready <= 1'b0;
               cnt           <= CW'(READ_LAT - 1);
               if (bound_err) begin
                  // Rejected stack op: no memory traffic, answer straight away.
                  state          <= RESP;
                  bus.resp_valid <= 1'b1;
                  bus.resp_err   <= 1'b1;
                  bus.resp_rdata <= '0;
               end else begin
                  state         <= ACCESS;
                  bus.mem_read  <= is_read;
                  bus.mem_write <= !is_read;
                  bus.mem_addr  <= acc_addr;
                  if (!is_read) bus.mem_wdata <= bus.req_wdata;
               end
            end
            ACCESS, WAIT: begin
               if (bus.mem_write || (cnt == '0)) begin
                  state          <= RESP;
                  bus.mem_read   <= 1'b0;
                  bus.mem_write  <= 1'b0;
                  bus.resp_valid <= 1'b1;
                  bus.resp_err   <= 1'b0;
                  bus.resp_rdata <= bus.mem_write ? '0 : bus.mem_rdata;
                  if (op == OP_PUSH)     sp_q <= sp_dec;
                  else if (op == OP_POP) sp_q <= sp_inc;
               end else begin
                  state <= WAIT;
                  cnt   <= cnt - CW'(1);
               end
            end
            RESP: begin
               state          <= IDLE;
               bus.resp_valid <= 1'b0;
               bus.resp_err   <= 1'b0;
               bus.resp_rdata <= '0;
               bus.req_ready  <= 1'b1;
            end
            default: state <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_stack_mem_ctrl.sv
// Bench for stack_mem_ctrl: directed vectors, a READ_LAT=3 instance for multi-cycle and
// reset-abort cases, and random traffic against a queue/array reference model.
module tb_stack_mem_ctrl;
   localparam logic [1:0]  OP_LOAD = 2'b00, OP_STORE = 2'b01, OP_PUSH = 2'b10, OP_POP = 2'b11;
   localparam logic [31:0] SP_INIT = 32'h0000_1000;
   localparam logic [31:0] LIMIT   = 32'h0000_0C00;
`ifdef STACK_BOUNDS_CHECK_EN
   localparam bit BCHK = 1'b1;
`else
   localparam bit BCHK = 1'b0;
`endif

   typedef struct {
      logic [31:0] rdata, sp, maddr, mwdata;
      logic [4:0]  rd;
      logic        err, both, early_rdy, resp_busy;
      int          lat, nrd, nwr;
   } res_t;

   typedef struct {
      logic [1:0]  op;
      logic [31:0] addr, wdata;
      logic [4:0]  rd;
      logic [31:0] rdata, sp, maddr;
   } vec_t;

   logic clk = 1'b0, rst = 1'b1, rst3 = 1'b1, clr1 = 1'b1, clr3 = 1'b1;
   int   checks = 0, failures = 0;
   int   rcnt1 = 0, rcnt3 = 0;
   logic [31:0] mem1 [0:4095];
   logic [31:0] mem3 [0:4095];
   logic [31:0] ref_mem [logic [31:0]];

   always #5 clk = ~clk;

   stack_mem_if #(.AW(32), .DW(32)) bus ();
   stack_mem_if #(.AW(32), .DW(32)) bus3 ();

   stack_mem_ctrl #(.READ_LAT(1)) dut  (.clk(clk), .reset(rst),  .bus(bus));
   stack_mem_ctrl #(.READ_LAT(3)) dut3 (.clk(clk), .reset(rst3), .bus(bus3));

   // Memory models: read data is only valid in the last cycle of the read window.
   always @(posedge clk) begin
      if (clr1) for (int i = 0; i < 4096; i++) mem1[i] <= '0;
      else if (bus.mem_write) mem1[bus.mem_addr[13:2]] <= bus.mem_wdata;
      rcnt1 <= bus.mem_read ? rcnt1 + 1 : 0;
      if (clr3) for (int i = 0; i < 4096; i++) mem3[i] <= '0;
      else if (bus3.mem_write) mem3[bus3.mem_addr[13:2]] <= bus3.mem_wdata;
      rcnt3 <= bus3.mem_read ? rcnt3 + 1 : 0;
   end

   always @(negedge clk) begin
      bus.mem_rdata  <= (bus.mem_read  && rcnt1 == 0) ? mem1[bus.mem_addr[13:2]]  : 32'hDEAD_BEEF;
      bus3.mem_rdata <= (bus3.mem_read && rcnt3 == 2) ? mem3[bus3.mem_addr[13:2]] : 32'hDEAD_BEEF;
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%h required=%h", name, act, exp);
      end
   endtask

   function automatic logic [31:0] ref_rd(input logic [31:0] a);
      return ref_mem.exists(a) ? ref_mem[a] : 32'h0;
   endfunction

   task automatic run_cmd(input logic [1:0] op, input logic [31:0] addr, input logic [31:0] wdata,
                          input logic [4:0] rd, output res_t r);
      int n;
      r = '{default: '0};
      n = 0;
      while (!bus.req_ready && n < 20) begin @(negedge clk); n++; end
      bus.req_valid = 1'b1; bus.req_op = op; bus.req_addr = addr;
      bus.req_wdata = wdata; bus.req_rd = rd;
      @(posedge clk);
      @(negedge clk);
      // Scramble request fields while busy; they must be ignored.
      bus.req_valid = 1'b0; bus.req_op = 2'($urandom); bus.req_addr = $urandom;
      bus.req_wdata = $urandom; bus.req_rd = 5'($urandom);
      n = 1;
      while (!bus.resp_valid && n < 20) begin
         if (bus.mem_write) begin r.nwr++; r.maddr = bus.mem_addr; r.mwdata = bus.mem_wdata; end
         if (bus.mem_read) begin r.nrd++; r.maddr = bus.mem_addr; end
         if (bus.mem_read && bus.mem_write) r.both = 1'b1;
         if (bus.req_ready) r.early_rdy = 1'b1;
         @(negedge clk); n++;
      end
      r.lat = n; r.rdata = bus.resp_rdata; r.rd = bus.resp_rd; r.err = bus.resp_err;
      r.sp = bus.sp; r.resp_busy = bus.mem_read | bus.mem_write | bus.req_ready;
   endtask

   task automatic chk_res(input string tag, input logic [1:0] op, input res_t r,
                          input logic [31:0] wdata, input logic [31:0] rdata, input logic [4:0] rd,
                          input logic err, input logic [31:0] sp, input logic [31:0] maddr);
      logic rdop;
      rdop = (op == OP_LOAD) || (op == OP_POP);
      chk({tag, ".rdata"}, r.rdata, rdata);
      chk({tag, ".rd"}, 32'(r.rd), 32'(rd));
      chk({tag, ".err"}, 32'(r.err), 32'(err));
      chk({tag, ".lat"}, 32'(r.lat), err ? 32'd1 : 32'd2);
      chk({tag, ".sp"}, r.sp, sp);
      chk({tag, ".maddr"}, r.maddr, err ? 32'h0 : maddr);
      chk({tag, ".nrd"}, 32'(r.nrd), (!err && rdop) ? 32'd1 : 32'd0);
      chk({tag, ".nwr"}, 32'(r.nwr), (!err && !rdop) ? 32'd1 : 32'd0);
      chk({tag, ".busy"}, {29'd0, r.both, r.early_rdy, r.resp_busy}, 32'd0);
      if (!err && !rdop) chk({tag, ".mwdata"}, r.mwdata, wdata);
   endtask

   task automatic cmd3(input logic [1:0] op, input logic [31:0] addr, input logic [31:0] wdata,
                       input logic [4:0] rd, output logic [31:0] rdata, output logic [31:0] sp_o,
                       output logic [4:0] rd_o, output logic [7:0] rd_mask,
                       output logic [7:0] rdy_mask, output int vld_at);
      int n;
      n = 0;
      while (!bus3.req_ready && n < 20) begin @(negedge clk); n++; end
      bus3.req_valid = 1'b1; bus3.req_op = op; bus3.req_addr = addr;
      bus3.req_wdata = wdata; bus3.req_rd = rd;
      @(posedge clk);
      rd_mask = '0; rdy_mask = '0; vld_at = 0; rdata = '0; sp_o = '0; rd_o = '0;
      for (int k = 1; k <= 7; k++) begin
         @(negedge clk);
         if (k == 1) bus3.req_valid = 1'b0;
         rd_mask[k]  = bus3.mem_read;
         rdy_mask[k] = bus3.req_ready;
         if (bus3.resp_valid && vld_at == 0) begin
            vld_at = k; rdata = bus3.resp_rdata; sp_o = bus3.sp; rd_o = bus3.resp_rd;
         end
      end
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog actual=timeout required=finish");
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
      $fatal(1);
   end

   initial begin
      vec_t        vt [9];
      res_t        r;
      logic [31:0] d, s, exp_rd, exp_sp, aw;
      logic [4:0]  ro;
      logic [7:0]  rm, ym;
      logic [1:0]  op;
      logic [31:0] addr, wdata;
      logic [4:0]  rd;
      logic        e;
      int          va, errs, seen;

      vt[0] = '{OP_STORE, 32'h0000_0006, 32'h1234_5678, 5'd2,  32'h0,         32'h1000, 32'h0000_0004};
      vt[1] = '{OP_LOAD,  32'h0000_0004, 32'h0,         5'd3,  32'h1234_5678, 32'h1000, 32'h0000_0004};
      vt[2] = '{OP_PUSH,  32'h0,         32'hAABB_CCDD, 5'd4,  32'h0,         32'h0FFC, 32'h0000_0FFC};
      vt[3] = '{OP_PUSH,  32'h5555_5555, 32'h1122_3344, 5'd5,  32'h0,         32'h0FF8, 32'h0000_0FF8};
      vt[4] = '{OP_POP,   32'h0,         32'h0,         5'd1,  32'h1122_3344, 32'h0FFC, 32'h0000_0FF8};
      vt[5] = '{OP_POP,   32'h0,         32'h0,         5'd1,  32'hAABB_CCDD, 32'h1000, 32'h0000_0FFC};
      vt[6] = '{OP_LOAD,  32'h0000_0FFF, 32'h0,         5'd31, 32'hAABB_CCDD, 32'h1000, 32'h0000_0FFC};
      vt[7] = '{OP_STORE, 32'hFFFF_FFFF, 32'hCAFE_F00D, 5'd0,  32'h0,         32'h1000, 32'hFFFF_FFFC};
      vt[8] = '{OP_LOAD,  32'hFFFF_FFFE, 32'h0,         5'd17, 32'hCAFE_F00D, 32'h1000, 32'hFFFF_FFFC};

      bus.req_valid = 0;  bus.req_op = 0;  bus.req_addr = 0;  bus.req_wdata = 0;  bus.req_rd = 0;
      bus3.req_valid = 0; bus3.req_op = 0; bus3.req_addr = 0; bus3.req_wdata = 0; bus3.req_rd = 0;

      // T1: reset state
      repeat (2) @(negedge clk);
      rst = 0; rst3 = 0; clr1 = 0; clr3 = 0;
      @(negedge clk);
      chk("rst.sp", bus.sp, SP_INIT);
      chk("rst.ready", 32'(bus.req_ready), 32'd1);
      chk("rst.strobes", {30'd0, bus.mem_read, bus.mem_write}, 32'd0);
      chk("rst.resp", {30'd0, bus.resp_valid, bus.resp_err}, 32'd0);
      chk("rst.mem_addr", bus.mem_addr, 32'd0);
      chk("rst3.sp", bus3.sp, SP_INIT);

      // T2/T3: directed vectors
      for (int i = 0; i < 9; i++) begin
         run_cmd(vt[i].op, vt[i].addr, vt[i].wdata, vt[i].rd, r);
         chk_res($sformatf("vec%0d", i), vt[i].op, r, vt[i].wdata, vt[i].rdata, vt[i].rd,
                 1'b0, vt[i].sp, vt[i].maddr);
      end

`ifdef STACK_BOUNDS_CHECK_EN
      // T5: underflow on empty stack, fill to limit, then overflow
      run_cmd(OP_POP, 0, 0, 5'd6, r);
      chk_res("underflow", OP_POP, r, 0, 32'h0, 5'd6, 1'b1, SP_INIT, 0);
      errs = 0;
      for (int i = 0; i < 256; i++) begin
         run_cmd(OP_PUSH, 0, 32'hB000_0000 + 32'(i), 5'd8, r);
         if (r.err) errs++;
      end
      chk("fill.errs", 32'(errs), 32'd0);
      chk("fill.sp", r.sp, LIMIT);
      run_cmd(OP_PUSH, 0, 32'hFFFF_0000, 5'd9, r);
      chk_res("overflow", OP_PUSH, r, 0, 32'h0, 5'd9, 1'b1, LIMIT, 0);
      run_cmd(OP_POP, 0, 0, 5'd10, r);
      chk_res("pop_top", OP_POP, r, 0, 32'hB000_00FF, 5'd10, 1'b0, LIMIT + 4, LIMIT);
`else
      // No bounds check: POP past the empty mark just walks upward.
      run_cmd(OP_POP, 0, 0, 5'd6, r);
      chk_res("pop_empty", OP_POP, r, 0, 32'h0, 5'd6, 1'b0, SP_INIT + 4, SP_INIT);
      run_cmd(OP_PUSH, 0, 32'h0000_0099, 5'd7, r);
      chk_res("push_back", OP_PUSH, r, 32'h99, 32'h0, 5'd7, 1'b0, SP_INIT, SP_INIT);
`endif

      // T4: READ_LAT=3 POP timing
      cmd3(OP_PUSH, 0, 32'h5A5A_5A5A, 5'd2, d, s, ro, rm, ym, va);
      chk("t4.push.vld_at", 32'(va), 32'd2);
      chk("t4.push.sp", s, 32'h0FFC);
      cmd3(OP_POP, 0, 0, 5'd7, d, s, ro, rm, ym, va);
      chk("t4.pop.rd_mask", 32'(rm), 32'h0E);
      chk("t4.pop.rdy_mask", 32'(ym), 32'hE0);
      chk("t4.pop.vld_at", 32'(va), 32'd4);
      chk("t4.pop.rdata", d, 32'h5A5A_5A5A);
      chk("t4.pop.sp", s, SP_INIT);
      chk("t4.pop.rd", 32'(ro), 32'd7);

      // T6: reset during WAIT of a LOAD
      cmd3(OP_PUSH, 0, 32'h0000_0077, 5'd3, d, s, ro, rm, ym, va);
      chk("t6.push.sp", s, 32'h0FFC);
      bus3.req_valid = 1; bus3.req_op = OP_LOAD; bus3.req_addr = 32'h0FFE; bus3.req_rd = 5'd9;
      @(posedge clk);
      @(negedge clk); bus3.req_valid = 0;
      @(negedge clk);
      chk("t6.in_wait.mem_read", 32'(bus3.mem_read), 32'd1);
      rst3 = 1;
      @(posedge clk);
      @(negedge clk);
      chk("t6.abort.mem_read", 32'(bus3.mem_read), 32'd0);
      chk("t6.abort.resp", 32'(bus3.resp_valid), 32'd0);
      chk("t6.abort.sp", bus3.sp, SP_INIT);
      rst3 = 0;
      seen = 0;
      for (int k = 0; k < 5; k++) begin @(negedge clk); if (bus3.resp_valid) seen++; end
      chk("t6.no_resp", 32'(seen), 32'd0);
      cmd3(OP_LOAD, 32'h0FFC, 0, 5'd9, d, s, ro, rm, ym, va);
      chk("t6.after.rdata", d, 32'h77);
      chk("t6.after.vld_at", 32'(va), 32'd4);
      chk("t6.after.rd", 32'(ro), 32'd9);

      // Random traffic against the reference model
      rst = 1; clr1 = 1;
      repeat (2) @(negedge clk);
      rst = 0; clr1 = 0;
      @(negedge clk);
      exp_sp = SP_INIT;
      ref_mem.delete();
      for (int t = 0; t < 300; t++) begin
         op    = 2'($urandom_range(0, 3));
         addr  = 32'h200 + 32'($urandom_range(0, 15)) * 4 + 32'($urandom_range(0, 3));
         wdata = $urandom;
         rd    = 5'($urandom);
         aw    = addr & ~32'h3;
         exp_rd = 32'h0;
         e     = 1'b0;
         case (op)
            OP_LOAD:  exp_rd = ref_rd(aw);
            OP_STORE: ref_mem[aw] = wdata;
            OP_PUSH:  if (BCHK && (exp_sp - 4 < LIMIT)) e = 1'b1;
                      else begin exp_sp = exp_sp - 4; ref_mem[exp_sp] = wdata; aw = exp_sp; end
            default:  if (BCHK && (exp_sp >= SP_INIT)) e = 1'b1;
                      else begin exp_rd = ref_rd(exp_sp); aw = exp_sp; exp_sp = exp_sp + 4; end
         endcase
         run_cmd(op, addr, wdata, rd, r);
         chk_res($sformatf("rnd%0d", t), op, r, wdata, exp_rd, rd, e, exp_sp, aw);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
